// File: rtl/rfsoc_config.sv
// Shared definitions for the RFSoC streaming blocks.
//   router_state_t   : axis_channel_router FSM states
//   AXIS_DW          : PS DMA stream data width
//   HDR_*_LSB        : bit offsets of the router header fields
//   ROUTER_MAGIC     : header tag expected when ROUTER_HDR_CHK_EN is defined
//   ch_onehot()      : one-hot decode of a channel index, callers truncate
package rfsoc_config;

    typedef enum logic [1:0] {
        RT_IDLE  = 2'd0,
        RT_ROUTE = 2'd1,
        RT_DRAIN = 2'd2
    } router_state_t;

    localparam int          AXIS_DW      = 256;
    localparam int          HDR_TAG_LSB  = 0;
    localparam int          HDR_CH_LSB   = 16;
    localparam int          HDR_LEN_LSB  = 32;
    localparam logic [15:0] ROUTER_MAGIC = 16'hA5C3;

    // Full 256-wide decode; the caller casts down to its channel count.
    function automatic logic [255:0] ch_onehot(input logic [7:0] ch);
        ch_onehot = 256'd1 << ch;
    endfunction

endpackage

// File: rtl/axis_channel_router.sv
// axis_channel_router: 1-to-NUM_CH AXI-Stream router.
// A header beat (tag [15:0], channel [23:16], payload count [32+CNT_W-1:32])
// selects a channel; the following N beats pass through to that channel with
// zero latency while select_out holds the channel's loopback mux on PS data.
// Bad headers (channel out of range, or wrong tag when ROUTER_HDR_CHK_EN is
// defined) have their payload drained and bump a saturating error counter.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready     upstream stream from PS DMA
//   m_axis_tdata                   payload broadcast to all channels
//   m_axis_tvalid/tready           per-channel handshake (one-hot valid)
//   select_out                     one-hot channel select for the whole load
//   busy                           FSM not in IDLE
//   done                           one-cycle pulse at end of a routed packet
//   err_cnt                        dropped-packet count, saturating
// Configuration macro: ROUTER_HDR_CHK_EN enables the header tag check.
module axis_channel_router
    import rfsoc_config::*;
#(
    parameter int          NUM_CH = 16,
    parameter int          CNT_W  = 24,
    parameter logic [15:0] MAGIC  = ROUTER_MAGIC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AXIS_DW-1:0]  s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [AXIS_DW-1:0]  m_axis_tdata,
    output logic [NUM_CH-1:0]   m_axis_tvalid,
    input  logic [NUM_CH-1:0]   m_axis_tready,
    output logic [NUM_CH-1:0]   select_out,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_cnt
);

    router_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         ch_q, ch_d;
    logic [NUM_CH-1:0]  select_q, select_d;
    logic               done_q, done_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic [7:0]         hdr_ch_s;
    logic [CNT_W-1:0]   hdr_len_s;
    logic               hdr_bad_s;
    logic [NUM_CH-1:0]  ch_dec_s;
    logic [NUM_CH-1:0]  hdr_dec_s;
    logic               s_ready_s;
    logic [NUM_CH-1:0]  m_valid_s;

    assign hdr_ch_s  = s_axis_tdata[HDR_CH_LSB +: 8];
    assign hdr_len_s = s_axis_tdata[HDR_LEN_LSB +: CNT_W];
    assign ch_dec_s  = NUM_CH'(ch_onehot(ch_q));
    assign hdr_dec_s = NUM_CH'(ch_onehot(hdr_ch_s));

`ifdef ROUTER_HDR_CHK_EN
    // Header is rejected for an out-of-range channel or a wrong tag.
    always_comb begin
        hdr_bad_s = ({1'b0, hdr_ch_s} >= 9'(NUM_CH)) ||
                    (s_axis_tdata[HDR_TAG_LSB +: 16] != MAGIC);
    end
`else
    // Header is rejected only for an out-of-range channel.
    always_comb begin
        hdr_bad_s = ({1'b0, hdr_ch_s} >= 9'(NUM_CH));
    end
`endif

    // Next-state, counter, select and handshake logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        select_d  = select_q;
        done_d    = 1'b0;
        err_cnt_d = err_cnt_q;
        s_ready_s = 1'b0;
        m_valid_s = '0;
        case (state_q)
            RT_IDLE: begin
                s_ready_s = 1'b1;
                if (s_axis_tvalid) begin
                    ch_d  = hdr_ch_s;
                    cnt_d = hdr_len_s;
                    if (hdr_bad_s) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        // A zero-length bad packet has nothing to drain.
                        if (hdr_len_s != '0) begin
                            state_d = RT_DRAIN;
                        end else begin
                            state_d = RT_IDLE;
                        end
                    end else if (hdr_len_s == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RT_ROUTE;
                        select_d = hdr_dec_s;
                    end
                end else begin
                    state_d = RT_IDLE;
                end
            end
            RT_ROUTE: begin
                // Pass-through: ready of the selected channel only.
                m_valid_s = ch_dec_s & {NUM_CH{s_axis_tvalid}};
                s_ready_s = |(m_axis_tready & ch_dec_s);
                if (s_axis_tvalid && s_ready_s) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = RT_IDLE;
                        select_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        state_d = RT_ROUTE;
                    end
                end else begin
                    state_d = RT_ROUTE;
                end
            end
            RT_DRAIN: begin
                s_ready_s = 1'b1;
                if (s_axis_tvalid) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RT_IDLE;
                    end else begin
                        state_d = RT_DRAIN;
                    end
                end else begin
                    state_d = RT_DRAIN;
                end
            end
            default: begin
                state_d  = RT_IDLE;
                select_d = '0;
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RT_IDLE;
            cnt_q     <= '0;
            ch_q      <= 8'd0;
            select_q  <= '0;
            done_q    <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            select_q  <= select_d;
            done_q    <= done_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Handshakes are held low while reset is asserted so nothing is accepted.
    assign s_axis_tready = s_ready_s & ~rst;
    assign m_axis_tvalid = m_valid_s & {NUM_CH{~rst}};
    assign m_axis_tdata  = s_axis_tdata;
    assign select_out    = select_q;
    assign busy          = (state_q != RT_IDLE);
    assign done          = done_q;
    assign err_cnt       = err_cnt_q;

endmodule
